// File: rtl/fifo_sched_pkg.sv
// fifo_sched_pkg: shared states, requester select and sizes for the FIFO scheduler.
package fifo_sched_pkg;
  typedef enum logic {STREAM, BLOCK} state_e;
  typedef enum logic {SEL_A, SEL_B} sel_e;
  localparam int FIFO_DEPTH  = 16;
  localparam int BLOCK_BYTES = 16;
  localparam int BLOCK_WIDTH = 128;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-requester round-robin grant; preference moves to the other side after each transfer.
module rr_arbiter2
  import fifo_sched_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic xfer_a,
  input  logic xfer_b,
  output logic gnt_a,
  output logic gnt_b
);
  sel_e rr_q, rr_d;
  always_ff @(posedge clk or negedge reset)
    if (!reset) rr_q <= SEL_A;
    else rr_q <= rr_d;
  // each grant looks only at the other requester, so a ready never depends on its own valid
  always_comb begin
    rr_d  = xfer_a ? SEL_B : xfer_b ? SEL_A : rr_q;
    gnt_a = rr_q == SEL_A || !req_b;
    gnt_b = rr_q == SEL_B || !req_a;
  end
endmodule

// File: rtl/fifo_scheduler.sv
// fifo_scheduler: round-robin A/B byte writes into a 16-entry FIFO and valid/ready streaming of its head.
// Defining FIFO_SCHED_BLOCK_EN adds a 128-bit block load serialized into 16 byte writes.
module fifo_scheduler
  import fifo_sched_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int ADDR_SPACE_EXP = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    a_valid,
  input  logic [DATA_SIZE-1:0]    a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [DATA_SIZE-1:0]    b_data,
  output logic                    b_ready,
`ifdef FIFO_SCHED_BLOCK_EN
  input  logic                    blk_valid,
  input  logic [BLOCK_WIDTH-1:0]  blk_data,
  output logic                    blk_ready,
`endif
  output logic                    out_valid,
  output logic [DATA_SIZE-1:0]    out_data,
  input  logic                    out_ready,
  output logic                    fifo_write,
  output logic                    fifo_read,
  output logic [DATA_SIZE-1:0]    fifo_wdata,
  input  logic [DATA_SIZE-1:0]    fifo_rdata,
  input  logic                    fifo_full,
  input  logic                    fifo_empty,
  output logic [ADDR_SPACE_EXP:0] occupancy
);
  logic gnt_a, gnt_b, ab_en, a_xfer, b_xfer, blk_wr;
  logic [DATA_SIZE-1:0] blk_byte;
  logic [ADDR_SPACE_EXP:0] occ_q, occ_d;

  rr_arbiter2 u_arb (
    .clk(clk), .reset(reset), .req_a(a_valid), .req_b(b_valid),
    .xfer_a(a_xfer), .xfer_b(b_xfer), .gnt_a(gnt_a), .gnt_b(gnt_b)
  );

`ifdef FIFO_SCHED_BLOCK_EN
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [BLOCK_WIDTH-1:0] hold_q, hold_d;
  logic blk_take;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= STREAM;
      cnt_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hold_q  <= hold_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hold_d  = hold_q;
    if (blk_take) begin
      state_d = BLOCK;
      cnt_d   = '0;
      hold_d  = blk_data;
    end else if (blk_wr) begin
      cnt_d   = cnt_q + 4'd1;
      state_d = cnt_q == 4'(BLOCK_BYTES - 1) ? STREAM : BLOCK;
    end
  end
  // a block is only taken into a truly empty FIFO, so its 16 bytes always fit
  always_comb begin
    blk_ready = reset && state_q == STREAM && fifo_empty && occ_q == '0;
    blk_take  = blk_valid && blk_ready;
    blk_wr    = reset && state_q == BLOCK && !fifo_full;
    blk_byte  = hold_q[{cnt_q, 3'b000} +: DATA_SIZE];
    ab_en     = state_q == STREAM && !blk_take;
  end
`else
  assign blk_wr   = 1'b0;
  assign blk_byte = '0;
  assign ab_en    = 1'b1;
`endif

  assign a_ready = reset && ab_en && !fifo_full && gnt_a;
  assign b_ready = reset && ab_en && !fifo_full && gnt_b;
  assign a_xfer  = a_valid && a_ready;
  assign b_xfer  = b_valid && b_ready;

  always_comb begin
    fifo_write = a_xfer || b_xfer || blk_wr;
    fifo_wdata = blk_wr ? blk_byte : a_xfer ? a_data : b_data;
    out_valid  = !fifo_empty;
    out_data   = fifo_rdata;
    fifo_read  = reset && out_valid && out_ready;
    occ_d      = fifo_write && !fifo_read ? occ_q + 1'b1 :
                 fifo_read && !fifo_write ? occ_q - 1'b1 : occ_q;
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) occ_q <= '0;
    else occ_q <= occ_d;

  assign occupancy = occ_q;
endmodule

// File: tb/tb_fifo_scheduler.sv
// tb_fifo_scheduler: random and directed stimulus against a queue-based FIFO and transfer-order reference model.
module tb_fifo_scheduler;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0, out_ready = 1'b0, blk_valid = 1'b0;
  logic [W-1:0] a_data = '0, b_data = '0;
  logic [127:0] blk_data = '0;
  logic a_ready, b_ready, blk_ready, out_valid, fifo_write, fifo_read;
  logic fifo_full = 1'b0, fifo_empty = 1'b1;
  logic [W-1:0] out_data, fifo_wdata;
  logic [W-1:0] fifo_rdata = '0;
  logic [4:0] occupancy;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  fifo_scheduler dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
`ifdef FIFO_SCHED_BLOCK_EN
    .blk_valid(blk_valid), .blk_data(blk_data), .blk_ready(blk_ready),
`endif
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .fifo_write(fifo_write), .fifo_read(fifo_read), .fifo_wdata(fifo_wdata),
    .fifo_rdata(fifo_rdata), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .occupancy(occupancy)
  );
`ifndef FIFO_SCHED_BLOCK_EN
  assign blk_ready = 1'b0;
`endif

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // 16-entry FIFO with registered flags and a head that is visible without a read
  logic [W-1:0] mem[$];
  always @(posedge clk or negedge reset)
    if (!reset) begin
      mem.delete();
      fifo_empty <= 1'b1;
      fifo_full  <= 1'b0;
      fifo_rdata <= '0;
    end else begin
      if (fifo_read && mem.size() > 0) void'(mem.pop_front());
      if (fifo_write && mem.size() < 16) mem.push_back(fifo_wdata);
      fifo_empty <= mem.size() == 0;
      fifo_full  <= mem.size() == 16;
      fifo_rdata <= mem.size() > 0 ? mem[0] : '0;
    end

  // reference: expected byte order in the FIFO, pending block bytes, and which requester is preferred
  logic [W-1:0] exp_q[$];
  logic [W-1:0] blk_q[$];
  logic pref_b = 1'b0;
  always @(negedge clk) begin
    logic ea, eb, ew, er, eblk;
    logic [W-1:0] ed;
    if (!reset) begin
      check("rst_a_ready", a_ready, 0);
      check("rst_b_ready", b_ready, 0);
      check("rst_blk_ready", blk_ready, 0);
      check("rst_fifo_write", fifo_write, 0);
      check("rst_fifo_read", fifo_read, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_out_valid", out_valid, !fifo_empty);
      exp_q.delete();
      blk_q.delete();
      pref_b = 1'b0;
    end else begin
      ea = 0; eb = 0; ew = 0; eblk = 0; ed = '0;
      if (blk_q.size() > 0) begin
        ew = !fifo_full;
        ed = blk_q[0];
      end else if (blk_valid && fifo_empty && exp_q.size() == 0) eblk = 1;
      else if (!fifo_full) begin
        ea = a_valid && (!pref_b || !b_valid);
        eb = b_valid && !ea;
        ew = ea || eb;
        ed = ea ? a_data : b_data;
      end
      er = !fifo_empty && out_ready;
      check("a_xfer", a_valid && a_ready, ea);
      check("b_xfer", b_valid && b_ready, eb);
      check("fifo_write", fifo_write, ew);
      if (ew) check("fifo_wdata", fifo_wdata, ed);
      check("fifo_read", fifo_read, er);
      check("out_valid", out_valid, !fifo_empty);
      if (er) check("out_data", out_data, exp_q.size() > 0 ? exp_q[0] : 'x);
      check("occupancy", occupancy, exp_q.size());
      if (fifo_full) check("ready_when_full", a_ready || b_ready, 0);
`ifdef FIFO_SCHED_BLOCK_EN
      check("blk_ready", blk_ready, blk_q.size() == 0 && fifo_empty && exp_q.size() == 0);
      if (blk_q.size() > 0 || eblk) check("ab_ready_in_block", a_ready || b_ready, 0);
`endif
      if (er && exp_q.size() > 0) void'(exp_q.pop_front());
      if (ew) exp_q.push_back(ed);
      if (ew && blk_q.size() > 0) void'(blk_q.pop_front());
      if (ea) pref_b = 1'b1;
      if (eb) pref_b = 1'b0;
      if (eblk) for (int i = 0; i < 16; i++) blk_q.push_back(blk_data[8*i +: 8]);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    a_valid = 0; b_valid = 0; blk_valid = 0; out_ready = 1;
    step(40);
  endtask

  initial begin
    int n;
    logic ok;
    step(3);
    reset = 1;
    // both requesters valid: writes alternate starting with A
    out_ready = 1; a_valid = 1; b_valid = 1;
    for (int i = 0; i < 30; i++) begin
      a_data = W'($urandom); b_data = W'($urandom);
      step(1);
    end
    drain();
    // only B, consumer stalled: fills to 16 and then holds off
    out_ready = 0; b_valid = 1;
    for (int i = 0; i < 20; i++) begin
      b_data = W'($urandom);
      step(1);
    end
    @(negedge clk);
    check("fill_occupancy", occupancy, 16);
    check("fill_b_ready", b_ready, 0);
    check("fill_full", fifo_full, 1);
    @(posedge clk); #1;
    out_ready = 1;
    step(5);
    drain();
    // empty FIFO with consumer ready: byte emerges the cycle after the write
    a_valid = 1; a_data = 8'h5A;
    @(negedge clk);
    check("empty_no_read", fifo_read, 0);
    @(posedge clk); #1;
    a_valid = 0;
    @(negedge clk);
    check("next_cycle_out_valid", out_valid, 1);
    check("next_cycle_out_data", out_data, 8'h5A);
    @(posedge clk); #1;
    drain();
`ifdef FIFO_SCHED_BLOCK_EN
    // block into empty FIFO while A is also asking
    blk_data = 128'h0F0E0D0C0B0A09080706050403020100;
    blk_valid = 1; a_valid = 1; a_data = 8'hAA; out_ready = 1;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk); ok = blk_ready;
      @(posedge clk); #1;
    end
    blk_valid = 0;
    check("blk_accept_empty", ok, 1);
    step(25);
    drain();
    // block waits while three bytes are held, accepted once drained
    out_ready = 0; a_valid = 1;
    step(3);
    a_valid = 0; blk_valid = 1; blk_data = {$urandom, $urandom, $urandom, $urandom};
    step(4);
    @(negedge clk);
    check("blk_wait_occupancy", occupancy, 3);
    check("blk_wait_ready", blk_ready, 0);
    @(posedge clk); #1;
    out_ready = 1;
    ok = 0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk); ok = blk_ready;
      @(posedge clk); #1;
    end
    blk_valid = 0;
    check("blk_accept_after_drain", ok, 1);
    drain();
    // reset during serialization after byte 7
    out_ready = 0; blk_valid = 1; blk_data = {$urandom, $urandom, $urandom, $urandom};
    step(1);
    blk_valid = 0;
    n = 0;
    for (int i = 0; i < 40 && n < 8; i++) begin
      @(negedge clk); if (fifo_write) n++;
      @(posedge clk); #1;
    end
    check("blk_bytes_before_reset", n, 8);
    reset = 0;
    step(2);
    reset = 1;
    step(2);
    @(negedge clk);
    check("post_reset_stream", blk_ready, 1);
    check("post_reset_occupancy", occupancy, 0);
    @(posedge clk); #1;
`endif
    // random traffic
    for (int i = 0; i < 600; i++) begin
      a_valid = $urandom_range(0, 3) != 0;
      b_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      a_data = W'($urandom); b_data = W'($urandom);
`ifdef FIFO_SCHED_BLOCK_EN
      blk_valid = $urandom_range(0, 15) == 0;
      blk_data = {$urandom, $urandom, $urandom, $urandom};
`endif
      step(1);
    end
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_scheduler.md
# fifo_scheduler

Arbitrating write-side and sequencing read-side controller for the 16-entry byte FIFO. Shares the FIFO write port between two byte requesters (A, B) with round-robin fairness, and serializes 128-bit blocks into 16 byte writes. Presents the FIFO output as a valid/ready stream to one consumer. Guarantees the FIFO never sees a write while full or a read while empty, including simultaneous read/write.

## Interface
- DATA_SIZE, 8, FIFO word width in bits
- ADDR_SPACE_EXP, 4, FIFO address bits; depth = 2**ADDR_SPACE_EXP = 16
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  asynchronous, active-low reset
- a_valid / a_data / a_ready  in / in / out  1 / DATA_SIZE / 1  requester A byte handshake
- b_valid / b_data / b_ready  in / in / out  1 / DATA_SIZE / 1  requester B byte handshake
- blk_valid / blk_data / blk_ready  in / in / out  1 / 128 / 1  block load handshake (macro-gated)
- out_valid / out_data / out_ready  out / out / in  1 / DATA_SIZE / 1  consumer stream
- fifo_write / fifo_read  output  1 each  FIFO write_to_fifo / read_from_fifo strobes
- fifo_wdata  output  DATA_SIZE  FIFO write_data_in
- fifo_rdata  input  DATA_SIZE  FIFO read_data_out (combinational head)
- fifo_full / fifo_empty  input  1 each  FIFO flags (registered in FIFO)
- occupancy  output  ADDR_SPACE_EXP+1  bytes held, 0..16

## Operation
- States: STREAM (byte arbitration), BLOCK (serializing). Reset -> STREAM.
- Transfer on a channel = valid & ready same cycle; ready never depends combinationally on that channel's own valid.
- STREAM: grant = rr-preferred requester if valid, else the other. a_ready/b_ready high only for granted requester, only when !fifo_full. After a granted transfer, rr flips to the other requester; rr unchanged with no transfer. Reset rr = A.
- fifo_write = accepted transfer; fifo_wdata = granted data.
- Block accept (STREAM only): blk_ready = fifo_empty & occupancy==0; block wins over A/B that cycle (a_ready=b_ready=0). Capture blk_data into 128-bit holding reg, clear 4-bit byte counter, go to BLOCK.
- BLOCK: each cycle with !fifo_full, write byte[cnt] = hold[8*cnt+7:8*cnt], cnt++. Byte 0 = blk_data[7:0]. After byte 15 written -> STREAM. a_ready=b_ready=blk_ready=0 throughout.
- Read side (all states): out_valid = !fifo_empty; out_data = fifo_rdata; fifo_read = out_valid & out_ready.
- occupancy: +1 on write only, -1 on read only, unchanged on both/neither; never exceeds 16 nor underflows.
- FIFO write_all is not driven by this block (tied 0 at parent).

## Timing
- Reset values: state STREAM, rr A, cnt 0, occupancy 0, hold reg 0. While reset low, all ready outputs, fifo_write, fifo_read held 0; out_valid follows fifo_empty.
- Write latency: accepted byte visible at out_valid one cycle later (FIFO empty flag registered).
- Full: fifo_full high -> no write strobe, readies low; concurrent read that cycle does not re-enable write until next cycle.
- Simultaneous read+write only when !fifo_empty & !fifo_full.
- Block: accept cycle + 16 write cycles minimum; stalls add one cycle per full cycle.
- Reset mid-BLOCK: remaining bytes discarded, return to STREAM.

## Configuration
- FIFO_SCHED_BLOCK_EN defined: blk_* ports, BLOCK state, holding reg and counter present as above.
- Undefined: blk_* ports removed, FSM stays STREAM permanently, only A/B arbitration and read streaming remain.

## Structure
- Package fifo_sched_pkg: state enum (STREAM, BLOCK), FIFO_DEPTH = 16, BLOCK_BYTES = 16, BLOCK_WIDTH = 128, rr select enum (SEL_A, SEL_B).
- Sub-module rr_arbiter2: two-request round-robin grant with rr register, advance-on-transfer input.

## Test plan
- A and B both valid continuously, out_ready=1 -> writes alternate A,B,A,B starting with A; out_data order matches.
- Only B valid 20 cycles, out_ready=0 -> 16 bytes accepted, b_ready low from cycle 17, occupancy=16, no write while fifo_full.
- FIFO empty, blk_data=128'h0F0E..0100 -> blk_ready pulse, 16 writes, out_data stream 00,01..0F; A held off during BLOCK.
- blk_valid with occupancy=3 -> blk_ready stays 0 until drained to 0, then accepted.
- out_ready=1 with FIFO empty, A valid -> fifo_read never asserted while fifo_empty; byte emerges next cycle.
- reset low at block byte 7 -> state STREAM, occupancy 0, all strobes 0 during reset.
